// File: rtl/serie_pkg.sv
// -----------------------------------------------------------------------------
// serie_pkg
// Shared definitions for the serial/parallel pair:
//   - state_t       : receiver FSM states {IDLE, RUN}
//   - DEFAULT_WIDTH : word width shared with the upstream serializer
//   - cnt_width()   : bit counter width, clog2 of the word width (min 1)
// -----------------------------------------------------------------------------
package serie_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 6;

    // Counter only has to hold 0..w-1, so clog2(w) bits are enough.
    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serieparalelo.sv
// -----------------------------------------------------------------------------
// serieparalelo
// Serial-to-parallel receiver. Aligns to the upstream frame-start strobe and
// assembles WIDTH bits, LSB first, into a parallel word presented with a
// one-cycle valid pulse. After the first strobe it runs continuously.
//
// Ports:
//   clk        : system clock, rising edge
//   clr        : synchronous reset, active high
//   ena_in     : frame-start strobe; bit on `in` in the same cycle is bit 0
//   in         : serial data bit
//   out        : last completed parallel word (held until the next one)
//   out_valid  : one-cycle pulse when `out` is updated
//   busy       : high while in RUN
//   sync_err   : sticky, strobe arrived mid-word (cleared only by clr)
//   frame_cnt  : [15:0] saturating count of emitted words
//                (only when SERIEPARALELO_FRAME_CNT_EN is defined)
//
// Configuration macro: SERIEPARALELO_FRAME_CNT_EN
// -----------------------------------------------------------------------------
module serieparalelo
    import serie_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             ena_in,
    input  logic             in,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic             busy,
    output logic             sync_err
`ifdef SERIEPARALELO_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_cnt
`endif
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_out;
    logic             r_out_valid;
    logic             r_busy;
    logic             r_sync_err;

    logic             w_start;     // strobe seen in IDLE
    logic             w_misalign;  // strobe in RUN with a partial word pending
    logic             w_emit;      // last bit of an aligned word this cycle
    logic             w_run;       // ordinary bit capture in RUN

    // State register; busy is registered from the next state so it tracks RUN.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == RUN);
        end
    end

    // Next-state logic: RUN is left only through clr.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (ena_in) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = IDLE;
                end
            end
            RUN:     w_next_state = RUN;
            default: w_next_state = IDLE;
        endcase
    end

    // Decode of the datapath action for this cycle.
    always_comb begin
        w_start    = 1'b0;
        w_misalign = 1'b0;
        w_emit     = 1'b0;
        w_run      = 1'b0;
        case (r_state)
            IDLE: w_start = ena_in;
            RUN: begin
                // A strobe on the last bit still counts as misaligned: drop it.
                if (ena_in && (r_cnt != '0)) begin
                    w_misalign = 1'b1;
                end else if (r_cnt == LAST) begin
                    w_emit = 1'b1;
                end else begin
                    w_run = 1'b1;
                end
            end
            default: begin
                w_start = 1'b0;
            end
        endcase
    end

    // Shift register, bit counter and word output.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out <= {in, r_shift[WIDTH-2:0]};
                r_cnt <= '0;
            end else if (w_start || w_misalign) begin
                // Restart the word: the bit beside the strobe is bit 0.
                r_shift[0] <= in;
                r_cnt      <= CW'(1);
            end else if (w_run) begin
                r_shift[r_cnt] <= in;
                r_cnt          <= r_cnt + CW'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            if (w_misalign) begin
                r_sync_err <= 1'b1;
            end else begin
                r_sync_err <= r_sync_err;
            end
        end
    end

`ifdef SERIEPARALELO_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    // Saturating count of emitted words; dropped words never reach w_emit.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_frame_cnt <= 16'h0000;
        end else if (w_emit && (r_frame_cnt != 16'hFFFF)) begin
            r_frame_cnt <= r_frame_cnt + 16'h0001;
        end else begin
            r_frame_cnt <= r_frame_cnt;
        end
    end

    assign frame_cnt = r_frame_cnt;
`endif

    assign out       = r_out;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign sync_err  = r_sync_err;

endmodule

// File: tb/tb_serieparalelo.sv
// -----------------------------------------------------------------------------
// tb_serieparalelo
// Scoreboard bench for serieparalelo. The stimulus task runs a bit-queue
// reference model and pushes each expected word with the cycle it should
// appear; an independent monitor pops and compares on every out_valid.
// -----------------------------------------------------------------------------
module tb_serieparalelo;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         tb_clr = 1'b1;
    logic         tb_ena = 1'b0;
    logic         tb_in = 1'b0;
    logic [W-1:0] tb_out;
    logic         tb_out_valid;
    logic         tb_busy;
    logic         tb_sync_err;
`ifdef SERIEPARALELO_FRAME_CNT_EN
    logic [15:0]  tb_frame_cnt;
`endif

    serieparalelo #(.WIDTH(W)) dut (
        .clk       (clk),
        .clr       (tb_clr),
        .ena_in    (tb_ena),
        .in        (tb_in),
        .out       (tb_out),
        .out_valid (tb_out_valid),
        .busy      (tb_busy),
        .sync_err  (tb_sync_err)
`ifdef SERIEPARALELO_FRAME_CNT_EN
        ,
        .frame_cnt (tb_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Reference model state
    bit           m_run = 1'b0;
    bit           m_err = 1'b0;
    bit           m_bits[$];
    int           m_fc  = 0;
    logic [W-1:0] exp_q[$];
    int           exp_t[$];

    // Monitor state
    bit           mon_en = 1'b0;
    bit           clr_edge = 1'b0;
    logic [W-1:0] last_word = '0;
    int           n_valid = 0;

    always @(posedge clk) begin
        cyc      = cyc + 1;
        clr_edge = tb_clr;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests = tests + 1;
        if (act != exp) begin
            fails = fails + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares every presented word against the scoreboard queue.
    always @(negedge clk) begin
        if (mon_en) begin
            if (clr_edge) begin
                chk("clr_out", tb_out, 0);
                chk("clr_valid", tb_out_valid, 0);
                last_word = '0;
            end else if (tb_out_valid === 1'b1) begin
                n_valid = n_valid + 1;
                if (exp_q.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    chk("word", tb_out, exp_q[0]);
                    chk("word_cycle", cyc, exp_t[0]);
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                end
                last_word = tb_out;
            end else begin
                chk("out_hold", tb_out, last_word);
                if (exp_q.size() != 0 && exp_t[0] <= cyc) begin
                    chk("missing_valid", 0, 1);
                    void'(exp_q.pop_front());
                    void'(exp_t.pop_front());
                end
            end
        end
    end

    // One clock of stimulus with the reference model; checks status outputs.
    task automatic step(input bit c, input bit e, input bit b);
        logic [W-1:0] w;
        tb_clr = c;
        tb_ena = e;
        tb_in  = b;
        if (c) begin
            m_run = 1'b0;
            m_err = 1'b0;
            m_bits.delete();
            exp_q.delete();
            exp_t.delete();
            m_fc = 0;
        end else if (!m_run) begin
            if (e) begin
                m_run  = 1'b1;
                m_bits = {b};
            end
        end else if (e && m_bits.size() != 0) begin
            m_err  = 1'b1;
            m_bits = {b};
        end else begin
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                for (int k = 0; k < W; k++) w[k] = m_bits[k];
                exp_q.push_back(w);
                exp_t.push_back(cyc + 1);
                if (m_fc < 65535) m_fc = m_fc + 1;
                m_bits.delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("busy", tb_busy, m_run);
        chk("sync_err", tb_sync_err, m_err);
`ifdef SERIEPARALELO_FRAME_CNT_EN
        chk("frame_cnt", tb_frame_cnt, m_fc);
`endif
    endtask

    task automatic send_bits(input logic [W-1:0] w, input int n, input bit strobe);
        for (int i = 0; i < n; i++) step(1'b0, strobe && (i == 0), w[i]);
    endtask

    initial begin : stim
        int nv0;
        @(negedge clk);
        #1;
        // Reset and idle with random data
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0);
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)));
            chk("idle_out", tb_out, 0);
            chk("idle_valid", tb_out_valid, 0);
        end

        // Single word 1,0,1,1,0,1 -> 0x2D
        send_bits(6'h2D, W, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        chk("single_word", last_word, 6'h2D);

        // Continuous stream of 0x15 after one strobe
        step(1'b1, 1'b0, 1'b0);
        nv0 = n_valid;
        for (int k = 0; k < 5; k++) send_bits(6'h15, W, k == 0);
        step(1'b0, 1'b0, 1'b0);
        chk("stream_count", n_valid - nv0, 5);
        chk("stream_word", last_word, 6'h15);
        chk("stream_err", tb_sync_err, 0);

        // Resync at bit 3 of the second word
        step(1'b1, 1'b0, 1'b0);
        nv0 = n_valid;
        send_bits(6'h0C, W, 1'b1);
        send_bits(6'h13, 3, 1'b0);
        send_bits(6'h2A, W, 1'b1);
        chk("resync_count", n_valid - nv0, 2);
        chk("resync_word", last_word, 6'h2A);
        chk("resync_err", tb_sync_err, 1);
        nv0 = n_valid;
        send_bits(6'h07, W, 1'b1);
        chk("aligned_count", n_valid - nv0, 1);
        chk("aligned_word", last_word, 6'h07);
        chk("aligned_err", tb_sync_err, 1);

        // Strobe exactly on the last bit drops the word
        nv0 = n_valid;
        send_bits(6'h11, W - 1, 1'b0);
        send_bits(6'h3F, W, 1'b1);
        chk("last_bit_drop", n_valid - nv0, 1);

        // Reset mid-word, then a fresh word
        step(1'b1, 1'b0, 1'b0);
        send_bits(6'h1B, 4, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("midclr_out", tb_out, 0);
        chk("midclr_busy", tb_busy, 0);
        step(1'b0, 1'b0, 1'b1);
        send_bits(6'h3F, W, 1'b1);
        chk("after_clr_word", last_word, 6'h3F);

`ifdef SERIEPARALELO_FRAME_CNT_EN
        // Frame counter: 4 good words plus one dropped, then saturation
        step(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) send_bits(W'($urandom), W, k == 0);
        send_bits(6'h05, 3, 1'b0);
        send_bits(6'h09, 2, 1'b1);
        chk("fc_four", tb_frame_cnt, 4);
        step(1'b1, 1'b0, 1'b0);
        dut.r_frame_cnt = 16'hFFFE;
        m_fc = 65534;
        for (int k = 0; k < 3; k++) send_bits(W'($urandom), W, k == 0);
        chk("fc_sat", tb_frame_cnt, 16'hFFFF);
`endif

        // Randomized traffic
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 14) == 0),
                 1'($urandom_range(0, 1)));
        end
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serieparalelo.md
Name: serieparalelo

Overview:
- Serial-to-parallel receiver; sits directly downstream of the parallel-to-serial stage and consumes its `out`/`ena_out` pair.
- Tracks word alignment from the frame-start strobe and assembles WIDTH bits, LSB first, into a parallel word. Each completed word is presented with a one-cycle valid pulse.
- After the first strobe it runs continuously, matching the free-running upstream bit counter.

Parameters:
- WIDTH, 6, bits per word; must equal the upstream word width; legal range 2..32.

Ports:
- clk  input  1  system clock, all logic on rising edge
- clr  input  1  synchronous reset, active-high
- ena_in  input  1  frame-start strobe (upstream ena_out); the bit on `in` in the same cycle is bit 0
- in  input  1  serial data bit (upstream out)
- out  output  WIDTH  last completed parallel word
- out_valid  output  1  one-cycle pulse, `out` updated this cycle
- busy  output  1  high while in RUN state
- sync_err  output  1  sticky: strobe arrived mid-word

Behaviour:
- Reset values: clr=1 at an edge forces the following, from any state including mid-word: state=IDLE, bit counter=0, shift register=0, out=0, out_valid=0, busy=0, sync_err=0.
- States: IDLE and RUN.
- IDLE:
  - in is ignored while ena_in=0.
  - ena_in=1 → shift[0]<=in, cnt<=1, go to RUN.
  - Special case WIDTH==... not applicable, since WIDTH≥2.
- RUN:
  - Every cycle, shift[cnt]<=in and cnt<=cnt+1.
  - When cnt==WIDTH-1, at that edge: out<={in, shift[WIDTH-2:0]}, out_valid<=1, cnt<=0.
- Latency: out/out_valid are valid in the cycle after bit WIDTH-1 is presented on `in`, i.e. WIDTH cycles after the strobe cycle.
- out_valid is high for exactly one cycle per word. `out` holds its value until the next word completes.
- Strobe in RUN with cnt==0 (aligned): normal operation, no error.
- Strobe in RUN with cnt!=0 (misaligned): discard the partial word (no out_valid), shift[0]<=in, cnt<=1, sync_err<=1.
  - Exception: if cnt==WIDTH-1 at the same edge, treat it as misaligned. The word is dropped, not emitted.
- sync_err is cleared only by clr.
- RUN exits only via clr; ena_in=0 never stops reception.
- Counter width is clog2(WIDTH). cnt wraps explicitly at WIDTH-1 and never reaches WIDTH.
- busy = (state==RUN), registered.

Optional Feature:
- Macro: SERIEPARALELO_FRAME_CNT_EN.
- Defined:
  - Adds output `frame_cnt` [15:0], reset to 0 by clr.
  - Increments on every out_valid pulse and saturates at 16'hFFFF.
  - Misaligned/dropped words are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package `serie_pkg` holds:
  - state enum {IDLE, RUN};
  - localparam default word width 6 (shared with the upstream stage);
  - counter-width function based on clog2.
- No sub-module. The shift register and counter are small enough to live in one always block plus the FSM.

Test Plan:
- Reset/idle: hold clr 3 cycles, then toggle `in` randomly with ena_in=0 for 10 cycles → out=0, out_valid=0, busy=0 throughout.
- Single word: ena_in=1 with bits 1,0,1,1,0,1 on consecutive cycles → out=6'h2D, out_valid=1 for exactly one cycle, 6 cycles after the strobe.
- Continuous stream: drive the upstream serializer model with parallel 6'h15 held, after one strobe → out=6'h15 with out_valid every 6th cycle for 5 words, sync_err=0.
- Resync: strobe at bit 3 of the second word → no out_valid for the partial word, sync_err=1, next word aligned to the new strobe is correct (6'h2A). A subsequent aligned strobe (cnt==0) keeps sync_err at 1 and causes no drop.
- Reset mid-word: clr=1 at bit 4 → next cycle all outputs 0, state IDLE; a later strobe receives 6'h3F correctly.
- With SERIEPARALELO_FRAME_CNT_EN: 4 good words plus 1 dropped → frame_cnt=4; force the counter to 16'hFFFE, then 3 words → frame_cnt=16'hFFFF.
